f2h_sdram0_read_arbiter: RTL and testbench
==========================================

# f2h_sdram0_read_arbiter

Shares the HPS FPGA-to-SDRAM port 0 (read-only Avalon-MM, 29-bit word address, 64-bit data, 8-bit burstcount) between up to `NUM_REQ` FPGA-fabric read clients. Grants one burst at a time by round-robin, drives the Avalon command until accepted, and steers the returning beats to the granted client. Sits between the `soc_system` `hps_0_f2h_sdram0_data_*` conduit and fabric DMA/readers, clocked by the sdram0 clock.

## Interface
Parameters:
- `NUM_REQ`, 4: number of requesters (2..8).
- `MAX_BURST`, 64: largest legal burstcount. Larger requests are rejected.

Ports:
- `clk` in 1: sdram0 port clock; all logic is in this domain.
- `rst_n` in 1: synchronous, active-low reset.
- `req_valid` in NUM_REQ: per-client read request.
- `req_addr` in NUM_REQ*29: per-client 64-bit-word address, packed; client i is at [29i+28:29i].
- `req_burst` in NUM_REQ*8: per-client beat count, packed.
- `req_ready` out NUM_REQ: one-hot, one-cycle acceptance pulse.
- `rsp_valid` out NUM_REQ: one-hot beat strobe to the owning client.
- `rsp_data` out 64: beat data, shared by all clients.
- `rsp_last` out 1: qualifies the final beat of a burst.
- `err_pulse` out 1: one-cycle pulse on a rejected request or a spurious `readdatavalid`.
- `busy` out 1: high whenever the block is not in IDLE.
- `avm_address` out 29, `avm_burstcount` out 8, `avm_read` out 1: Avalon-MM command.
- `avm_waitrequest` in 1, `avm_readdata` in 64, `avm_readdatavalid` in 1: Avalon-MM response.

## Operation
- States: IDLE, ISSUE, DATA.
- IDLE: when any `req_valid` is high, the round-robin arbiter picks the first requester at or after `rr_ptr`.
  - The picked requester's address and burst are latched, and its `req_ready` pulses for one cycle.
  - `rr_ptr` is set to the winner+1, modulo NUM_REQ.
  - A burst of 0 or greater than MAX_BURST is accepted (`req_ready` pulses), raises `err_pulse`, issues no command, and the block stays in IDLE.
  - Otherwise the block goes to ISSUE.
- ISSUE:
  - `avm_read`=1, with `avm_address` and `avm_burstcount` driven from registers and held stable.
  - When `avm_waitrequest`=0: deassert `avm_read` next cycle, clear the beat counter, go to DATA.
- DATA:
  - Each `avm_readdatavalid` increments an 8-bit beat counter.
  - That beat is forwarded to the owner: `rsp_valid` one-hot, `rsp_data` = `avm_readdata`.
  - When counter+1 equals the latched burst, `rsp_last`=1 and the next state is IDLE.
- One burst is outstanding at a time; no new command is issued until the last beat returns.
- A `readdatavalid` seen in IDLE or ISSUE is dropped and raises `err_pulse`.
- Requesters hold `req_valid`, address and burst until `req_ready`. Dropping `req_valid` before grant withdraws the request with no side effect.

## Timing
- Reset values:
  - `avm_read`, `req_ready`, `rsp_valid`, `rsp_last`, `err_pulse` and `busy` are all 0.
  - `avm_address`, `avm_burstcount` and `rsp_data` are 0.
  - `rr_ptr` is 0 and the state is IDLE.
- Reset mid-burst aborts immediately. Beats arriving after reset are flagged as spurious.
- Grant latency: `req_valid` sampled high in IDLE gives `req_ready` and a registered `avm_read`=1 in the following cycle.
- Command hold: `avm_read`/address/burstcount stay constant while `avm_waitrequest`=1. `avm_read` is low the cycle after acceptance.
- Response latency: exactly 1 cycle from `avm_readdatavalid` to `rsp_valid`/`rsp_data`, all registered.
- Turnaround: the earliest next `avm_read` is 2 cycles after the cycle carrying the last `avm_readdatavalid`.
- Simultaneous requests: only the round-robin winner is granted; the others stay pending.
- Wrap-around: `rr_ptr` wraps from NUM_REQ-1 to 0.
- Burst 255 with MAX_BURST=255: the counter reaches 254 on the last beat and never overflows.

## Structure
- Package `f2h_sdram0_pkg` holds:
  - `ADDR_W`=29, `DATA_W`=64, `BURST_W`=8;
  - the state enum {IDLE, ISSUE, DATA}.
- Sub-module `rr_arbiter` (parameter N; inputs req[N], ptr; output grant one-hot, combinational). It is reused by future write-port arbiters.
- The top contains the FSM, command registers, beat counter and response steering.

## Test plan
- Single client 1, addr 0x0001000, burst 4, `waitrequest` high 3 cycles:
  - `avm_read` is held 4 cycles with constant address;
  - 4 `rsp_valid[1]` beats arrive, `rsp_last` on the 4th;
  - `busy` falls after.
- All 4 clients request burst 2 continuously:
  - grants go in order 0,1,2,3,0;
  - no client is granted twice before the others are served.
- Client 2 with burst 0, then burst 65 (MAX_BURST=64):
  - each gives a `req_ready[2]` pulse and `err_pulse`;
  - no `avm_read` is issued.
- `avm_readdatavalid` injected in IDLE: `err_pulse`=1, no `rsp_valid`.
- `rst_n` low after beat 3 of 8: all outputs are 0 next cycle; late beats are flagged and not forwarded.
- Back-to-back bursts with data returning with 0-wait `readdatavalid`: data matches, beats are in order, and the 2-cycle turnaround is met.

Source files
------------

// File: rtl/f2h_sdram0_pkg.sv
`default_nettype none
// ============================================================================
// Module      : f2h_sdram0_pkg
// Description : Shared widths and FSM state type for the HPS f2h_sdram0
//               read-port arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package f2h_sdram0_pkg;

  localparam int ADDR_W  = 29;  // 64-bit word address
  localparam int DATA_W  = 64;
  localparam int BURST_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DATA  = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/f2h_sdram0_read_arbiter_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter
// Description : Combinational round-robin picker. Grants the first active
//               request at or after ptr, wrapping modulo N. One-hot output,
//               all-zero when nothing is requested.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
  parameter int N     = 4,
  parameter int PTR_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N-1:0]     grant
);

  int   idx;
  logic found;

  // Scan from ptr upward with wrap; first hit wins.
  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < N; k++) begin
      idx = (k + int'(ptr)) % N;
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/f2h_sdram0_read_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : f2h_sdram0_read_arbiter
// Description : Shares the HPS FPGA-to-SDRAM port 0 read interface between
//               NUM_REQ fabric clients. One burst outstanding at a time,
//               round-robin grant, registered command and response paths.
// Revision    : 1.0 - initial release
// ============================================================================
module f2h_sdram0_read_arbiter
  import f2h_sdram0_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int MAX_BURST = 64
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ*ADDR_W-1:0]  req_addr,
  input  logic [NUM_REQ*BURST_W-1:0] req_burst,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic [NUM_REQ-1:0]         rsp_valid,
  output logic [DATA_W-1:0]          rsp_data,
  output logic                       rsp_last,
  output logic                       err_pulse,
  output logic                       busy,
  output logic [ADDR_W-1:0]          avm_address,
  output logic [BURST_W-1:0]         avm_burstcount,
  output logic                       avm_read,
  input  logic                       avm_waitrequest,
  input  logic [DATA_W-1:0]          avm_readdata,
  input  logic                       avm_readdatavalid
);

  localparam int                 PTR_W       = $clog2(NUM_REQ);
  localparam logic [BURST_W-1:0] MAX_BURST_C = BURST_W'(MAX_BURST);
  localparam logic [PTR_W-1:0]   LAST_PTR    = PTR_W'(NUM_REQ - 1);

  state_t             state;
  logic [PTR_W-1:0]   rr_ptr;
  logic [NUM_REQ-1:0] owner;
  logic [BURST_W-1:0] beat_cnt;

  logic [NUM_REQ-1:0] grant;
  logic [PTR_W-1:0]   win_idx;
  logic [PTR_W-1:0]   next_ptr;
  logic [ADDR_W-1:0]  pick_addr;
  logic [BURST_W-1:0] pick_burst;
  logic               burst_bad;
  logic               arb_en;

  rr_arbiter #(
    .N     (NUM_REQ),
    .PTR_W (PTR_W)
  ) u_rr_arbiter (
    .req   (req_valid),
    .ptr   (rr_ptr),
    .grant (grant)
  );

  // Encode the one-hot winner so its address/burst slice can be selected.
  always_comb begin
    win_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) win_idx = PTR_W'(i);
    end
  end

  assign pick_addr  = req_addr[int'(win_idx)*ADDR_W +: ADDR_W];
  assign pick_burst = req_burst[int'(win_idx)*BURST_W +: BURST_W];
  assign burst_bad  = (pick_burst == '0) || (pick_burst > MAX_BURST_C);
  assign next_ptr   = (win_idx == LAST_PTR) ? '0 : win_idx + PTR_W'(1);

  // A requester still shows valid during its req_ready cycle; arbitrating
  // then would re-grant the same request (matters after a rejected burst).
  assign arb_en = (|req_valid) && (req_ready == '0);

  assign busy = (state != IDLE);

  // Main FSM: grant, command issue, beat counting and response steering.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state          <= IDLE;
      rr_ptr         <= '0;
      owner          <= '0;
      beat_cnt       <= '0;
      req_ready      <= '0;
      rsp_valid      <= '0;
      rsp_data       <= '0;
      rsp_last       <= 1'b0;
      err_pulse      <= 1'b0;
      avm_address    <= '0;
      avm_burstcount <= '0;
      avm_read       <= 1'b0;
    end else begin
      req_ready <= '0;
      rsp_valid <= '0;
      rsp_last  <= 1'b0;
      err_pulse <= 1'b0;
      case (state)
        IDLE: begin
          if (avm_readdatavalid) err_pulse <= 1'b1;
          if (arb_en) begin
            req_ready <= grant;
            rr_ptr    <= next_ptr;
            if (burst_bad) begin
              err_pulse <= 1'b1;
            end else begin
              avm_address    <= pick_addr;
              avm_burstcount <= pick_burst;
              owner          <= grant;
              avm_read       <= 1'b1;
              state          <= ISSUE;
            end
          end
        end
        ISSUE: begin
          if (avm_readdatavalid) err_pulse <= 1'b1;
          if (!avm_waitrequest) begin
            avm_read <= 1'b0;
            beat_cnt <= '0;
            state    <= DATA;
          end
        end
        DATA: begin
          if (avm_readdatavalid) begin
            rsp_valid <= owner;
            rsp_data  <= avm_readdata;
            beat_cnt  <= beat_cnt + BURST_W'(1);
            if ((beat_cnt + BURST_W'(1)) == avm_burstcount) begin
              rsp_last <= 1'b1;
              state    <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_f2h_sdram0_read_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_f2h_sdram0_read_arbiter
// Description : Self-checking bench. Requester and Avalon slave behaviour are
//               driven from one initial block; expected grants come from a
//               round-robin pointer model, expected beats from the data the
//               slave returned.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_f2h_sdram0_read_arbiter;

  localparam int N    = 4;
  localparam int MAXB = 64;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   req_valid;
  logic [N*29-1:0] req_addr;
  logic [N*8-1:0] req_burst;
  logic [N-1:0]   req_ready;
  logic [N-1:0]   rsp_valid;
  logic [63:0]    rsp_data;
  logic           rsp_last;
  logic           err_pulse;
  logic           busy;
  logic [28:0]    avm_address;
  logic [7:0]     avm_burstcount;
  logic           avm_read;
  logic           avm_waitrequest;
  logic [63:0]    avm_readdata;
  logic           avm_readdatavalid;

  always #5 clk = ~clk;

  f2h_sdram0_read_arbiter #(
    .NUM_REQ   (N),
    .MAX_BURST (MAXB)
  ) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .req_valid         (req_valid),
    .req_addr          (req_addr),
    .req_burst         (req_burst),
    .req_ready         (req_ready),
    .rsp_valid         (rsp_valid),
    .rsp_data          (rsp_data),
    .rsp_last          (rsp_last),
    .err_pulse         (err_pulse),
    .busy              (busy),
    .avm_address       (avm_address),
    .avm_burstcount    (avm_burstcount),
    .avm_read          (avm_read),
    .avm_waitrequest   (avm_waitrequest),
    .avm_readdata      (avm_readdata),
    .avm_readdatavalid (avm_readdatavalid)
  );

  int          checks   = 0;
  int          failures = 0;
  int          rr_model = 0;
  logic [28:0] cur_addr  [N];
  logic [7:0]  cur_burst [N];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reqs();
    for (int i = 0; i < N; i++) begin
      req_addr[i*29 +: 29] = cur_addr[i];
      req_burst[i*8 +: 8]  = cur_burst[i];
    end
  endtask

  // Reference round-robin: first pending client at or after the pointer.
  function automatic int pick(input logic [N-1:0] v, input int ptr);
    for (int k = 0; k < N; k++) begin
      if (v[(ptr + k) % N]) return (ptr + k) % N;
    end
    return -1;
  endfunction

  task automatic grant_step(output int win);
    win = pick(req_valid, rr_model);
    tick();
    check("grant", {60'd0, req_ready}, (win < 0) ? 64'd0 : (64'd1 << win));
    if (win >= 0) rr_model = (win + 1) % N;
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_read"},  {63'd0, avm_read}, 64'd0);
    check({tag, "_ready"}, {60'd0, req_ready}, 64'd0);
    check({tag, "_rspv"},  {60'd0, rsp_valid}, 64'd0);
    check({tag, "_last"},  {63'd0, rsp_last}, 64'd0);
    check({tag, "_err"},   {63'd0, err_pulse}, 64'd0);
    check({tag, "_busy"},  {63'd0, busy}, 64'd0);
    check({tag, "_addr"},  {35'd0, avm_address}, 64'd0);
    check({tag, "_bc"},    {56'd0, avm_burstcount}, 64'd0);
    check({tag, "_data"},  rsp_data, 64'd0);
  endtask

  // Entered in the cycle after a grant. mode: 0 drop request, 1 keep it,
  // 2 replace it with a fresh random request.
  task automatic serve(input int c, input int waits, input bit gaps, input int mode);
    logic [28:0] a;
    logic [7:0]  b;
    logic [63:0] d;
    a = cur_addr[c];
    b = cur_burst[c];
    check("cmd_read",  {63'd0, avm_read}, 64'd1);
    check("cmd_addr",  {35'd0, avm_address}, {35'd0, a});
    check("cmd_burst", {56'd0, avm_burstcount}, {56'd0, b});
    check("busy_cmd",  {63'd0, busy}, 64'd1);
    if (mode == 0) begin
      req_valid[c] = 1'b0;
    end else if (mode == 2) begin
      cur_addr[c]  = 29'($urandom);
      cur_burst[c] = 8'($urandom_range(1, 8));
      apply_reqs();
      if ($urandom_range(0, 3) == 0) req_valid[c] = 1'b0;
    end
    for (int w = 0; w < waits; w++) begin
      avm_waitrequest = 1'b1;
      tick();
      check("hold_read",  {63'd0, avm_read}, 64'd1);
      check("hold_addr",  {35'd0, avm_address}, {35'd0, a});
      check("hold_burst", {56'd0, avm_burstcount}, {56'd0, b});
    end
    avm_waitrequest = 1'b0;
    tick();
    check("read_drop", {63'd0, avm_read}, 64'd0);
    for (int bt = 0; bt < int'(b); bt++) begin
      if (gaps && ($urandom_range(0, 1) == 1)) begin
        tick();
        check("gap_rspv", {60'd0, rsp_valid}, 64'd0);
      end
      d = {$urandom, $urandom};
      avm_readdatavalid = 1'b1;
      avm_readdata      = d;
      tick();
      avm_readdatavalid = 1'b0;
      check("rsp_valid", {60'd0, rsp_valid}, 64'd1 << c);
      check("rsp_data",  rsp_data, d);
      check("rsp_last",  {63'd0, rsp_last}, {63'd0, (bt == int'(b) - 1)});
    end
    check("busy_done", {63'd0, busy}, 64'd0);
  endtask

  initial begin
    int win;
    rst_n             = 1'b0;
    req_valid         = '0;
    req_addr          = '0;
    req_burst         = '0;
    avm_waitrequest   = 1'b0;
    avm_readdata      = '0;
    avm_readdatavalid = 1'b0;
    for (int i = 0; i < N; i++) begin
      cur_addr[i]  = '0;
      cur_burst[i] = '0;
    end

    // Reset state
    tick(); tick(); tick();
    check_quiet("rst");
    rst_n = 1'b1;
    tick();

    // Single client 1, burst 4, waitrequest high 3 cycles
    cur_addr[1]  = 29'h0001000;
    cur_burst[1] = 8'd4;
    apply_reqs();
    req_valid = 4'b0010;
    grant_step(win);
    serve(1, 3, 1'b0, 0);

    // Rejected bursts on client 2: 0 and MAX_BURST+1
    for (int r = 0; r < 2; r++) begin
      cur_burst[2] = (r == 0) ? 8'd0 : 8'(MAXB + 1);
      cur_addr[2]  = 29'h0002000;
      apply_reqs();
      req_valid = 4'b0100;
      grant_step(win);
      check("rej_err",  {63'd0, err_pulse}, 64'd1);
      check("rej_read", {63'd0, avm_read}, 64'd0);
      check("rej_busy", {63'd0, busy}, 64'd0);
      req_valid = '0;
      tick();
      check("rej_read2", {63'd0, avm_read}, 64'd0);
      check("rej_err2",  {63'd0, err_pulse}, 64'd0);
    end

    // Spurious readdatavalid in IDLE
    avm_readdatavalid = 1'b1;
    avm_readdata      = 64'hDEAD_BEEF_0000_0001;
    tick();
    avm_readdatavalid = 1'b0;
    check("spur_err",  {63'd0, err_pulse}, 64'd1);
    check("spur_rspv", {60'd0, rsp_valid}, 64'd0);

    // Reset after beat 3 of 8
    cur_addr[3]  = 29'h0003000;
    cur_burst[3] = 8'd8;
    apply_reqs();
    req_valid = 4'b1000;
    grant_step(win);
    req_valid = '0;
    tick();
    for (int bt = 0; bt < 3; bt++) begin
      logic [63:0] d;
      d = {$urandom, $urandom};
      avm_readdatavalid = 1'b1;
      avm_readdata      = d;
      tick();
      check("pre_rst_rspv", {60'd0, rsp_valid}, 64'd8);
      check("pre_rst_data", rsp_data, d);
    end
    rst_n = 1'b0;
    tick();
    check_quiet("midrst");
    rst_n    = 1'b1;
    rr_model = 0;
    tick();
    avm_readdatavalid = 1'b0;
    check("late_err",  {63'd0, err_pulse}, 64'd1);
    check("late_rspv", {60'd0, rsp_valid}, 64'd0);
    tick();

    // All clients requesting burst 2 continuously
    for (int i = 0; i < N; i++) begin
      cur_addr[i]  = 29'(32'h100 * (i + 1));
      cur_burst[i] = 8'd2;
    end
    apply_reqs();
    req_valid = '1;
    for (int n = 0; n < 5; n++) begin
      grant_step(win);
      if (win >= 0) serve(win, n % 2, 1'b0, 1);
    end
    req_valid = '0;
    tick();

    // Randomized back-to-back traffic
    for (int i = 0; i < N; i++) begin
      cur_addr[i]  = 29'($urandom);
      cur_burst[i] = 8'($urandom_range(1, 8));
    end
    apply_reqs();
    for (int n = 0; n < 14; n++) begin
      if (req_valid == '0) req_valid = 4'($urandom_range(1, 15));
      grant_step(win);
      if (win >= 0) serve(win, $urandom_range(0, 2), 1'($urandom_range(0, 1)), 2);
    end
    req_valid = '0;
    tick();
    check("end_busy", {63'd0, busy}, 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
